tt_stim_harness: RTL and testbench

Parametrised self-checking stimulus harness for a TT user-project under test (DUT). It replaces hand-driven ui_in/uio_in pins with an on-chip pseudo-random sequencer. It sequences the DUT's rst_n and ena, then compacts uo_out/uio_out into a multiple-input signature register (MISR). It sits between a bench or host controller and one DUT instance, giving a start/busy/done handshake and a pass flag against an expected signature.

---
 rtl/tt_stim_harness.sv | 222 ++++++++++++++++++++++
 tb/tb_tt_stim_harness.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_stim_harness.sv
// Stimulus/compaction harness for one TT user project: sequences DUT reset/enable,
// drives LFSR stimulus and folds DUT outputs into a 32-bit MISR. Option: HARNESS_OE_MASK_EN.
module tt_stim_harness #(
    parameter int          DATA_W       = 8,
    parameter int          RST_CYCLES   = 4,
    parameter int          RUN_LEN      = 256,
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       expected_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       signature,
    output logic              dut_rst_n,
    output logic              dut_ena,
    output logic [DATA_W-1:0] dut_ui,
    output logic [DATA_W-1:0] dut_uio_in,
    input  logic [DATA_W-1:0] dut_uo,
    input  logic [DATA_W-1:0] dut_uio_out,
    input  logic [DATA_W-1:0] dut_uio_oe
);

    localparam int MAX_A   = (RST_CYCLES > RUN_LEN) ? RST_CYCLES : RUN_LEN;
    localparam int MAX_CNT = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RST_DUT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [31:0] galois_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [31:0]       misr_q, misr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              rst_n_q, rst_n_d;
    logic              ena_q, ena_d;
    logic [DATA_W-1:0] ui_q, ui_d;
    logic [DATA_W-1:0] uio_q, uio_d;

    logic [31:0]       lfsr_step;
    logic [31:0]       misr_step;
    logic [31:0]       in32;
    logic [DATA_W-1:0] uio_lane;
    logic              enter_done;

`ifdef HARNESS_OE_MASK_EN
    // Undriven uio bits would otherwise inject floating values into the signature.
    assign uio_lane = dut_uio_out & dut_uio_oe;
`else
    logic unused_oe;
    assign uio_lane  = dut_uio_out;
    assign unused_oe = ^dut_uio_oe;
`endif

    always_comb begin
        in32                      = '0;
        in32[DATA_W-1:0]          = dut_uo;
        in32[2*DATA_W-1:DATA_W]   = uio_lane;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        misr_d     = misr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        rst_n_d    = rst_n_q;
        ena_d      = ena_q;
        ui_d       = ui_q;
        uio_d      = uio_q;
        enter_done = 1'b0;
        lfsr_step  = galois_step(lfsr_q);
        misr_step  = galois_step(misr_q) ^ in32;

        unique case (state_q)
            IDLE: begin
                rst_n_d = 1'b1;
                ena_d   = 1'b0;
                busy_d  = 1'b0;
                ui_d    = '0;
                uio_d   = '0;
                if (start) begin
                    state_d = RST_DUT;
                    lfsr_d  = LFSR_SEED;
                    misr_d  = '0;
                    cnt_d   = RST_LOAD;
                    busy_d  = 1'b1;
                    ena_d   = 1'b1;
                    rst_n_d = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            RST_DUT: begin
                if (cnt_q == '0) begin
                    // Present the seed on the first RUN cycle.
                    state_d = RUN;
                    cnt_d   = RUN_LOAD;
                    rst_n_d = 1'b1;
                    ui_d    = lfsr_q[DATA_W-1:0];
                    uio_d   = lfsr_q[DATA_W+15:16];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                lfsr_d = lfsr_step;
                misr_d = misr_step;
                if (cnt_q == '0) begin
                    if (DRAIN_CYCLES > 0) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        enter_done = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    ui_d  = lfsr_step[DATA_W-1:0];
                    uio_d = lfsr_step[DATA_W+15:16];
                end
            end
            DRAIN: begin
                misr_d = misr_step;
                if (cnt_q == '0) begin
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_done) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ena_d   = 1'b0;
            ui_d    = '0;
            uio_d   = '0;
            pass_d  = (misr_d == expected_sig);
        end

        // Abort freezes the partial signature and skips the done pulse.
        if (abort && (state_q == RST_DUT || state_q == RUN || state_q == DRAIN)) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            lfsr_d  = lfsr_q;
            misr_d  = misr_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            rst_n_d = 1'b1;
            ena_d   = 1'b0;
            ui_d    = '0;
            uio_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            rst_n_q <= 1'b0;
            ena_q   <= 1'b0;
            ui_q    <= '0;
            uio_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            rst_n_q <= rst_n_d;
            ena_q   <= ena_d;
            ui_q    <= ui_d;
            uio_q   <= uio_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = misr_q;
    assign dut_rst_n  = rst_n_q;
    assign dut_ena    = ena_q;
    assign dut_ui     = ui_q;
    assign dut_uio_in = uio_q;

endmodule

// File: tb/tb_tt_stim_harness.sv
// Bench for tt_stim_harness: a behavioural DUT model plus a reference LFSR/MISR model
// computed straight from the polynomial and the run/drain schedule.
module tb_tt_stim_harness;

    localparam int          DATA_W       = 8;
    localparam int          RST_CYCLES   = 4;
    localparam int          RUN_LEN      = 256;
    localparam int          DRAIN_CYCLES = 2;
    localparam int          TOTAL        = RUN_LEN + DRAIN_CYCLES;
    localparam logic [31:0] SEED         = 32'h0000_0001;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [31:0]       expected_sig;
    logic              busy;
    logic              done;
    logic              pass;
    logic [31:0]       signature;
    logic              dut_rst_n;
    logic              dut_ena;
    logic [DATA_W-1:0] dut_ui;
    logic [DATA_W-1:0] dut_uio_in;
    logic [DATA_W-1:0] dut_uo;
    logic [DATA_W-1:0] dut_uio_out;
    logic [DATA_W-1:0] dut_uio_oe;

    logic              echo_mode;
    logic [7:0]        flip_mask;
    logic [7:0]        uo_drv;
    logic [7:0]        uio_drv;
    logic [7:0]        oe_drv;
    logic [7:0]        uo_arr  [TOTAL];
    logic [7:0]        uio_arr [TOTAL];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // DUT stand-in: either echoes ui back on uo, or plays back per-cycle tables.
    assign dut_uo      = echo_mode ? (dut_ui ^ flip_mask) : uo_drv;
    assign dut_uio_out = uio_drv;
    assign dut_uio_oe  = oe_drv;

    tt_stim_harness dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .expected_sig (expected_sig),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .dut_rst_n    (dut_rst_n),
        .dut_ena      (dut_ena),
        .dut_ui       (dut_ui),
        .dut_uio_in   (dut_uio_in),
        .dut_uo       (dut_uo),
        .dut_uio_out  (dut_uio_out),
        .dut_uio_oe   (dut_uio_oe)
    );

    function automatic logic [31:0] poly_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Signature after RUN_LEN stimulus cycles and DRAIN_CYCLES hold cycles.
    function automatic logic [31:0] model_sig(input bit echo, input int flip_k);
        logic [31:0] lf  = SEED;
        logic [31:0] sig = 32'h0;
        logic [7:0]  uo;
        logic [7:0]  uio;
        for (int k = 0; k < TOTAL; k++) begin
            uo  = echo ? lf[7:0] : uo_arr[k];
            if (k == flip_k) uo = uo ^ 8'h01;
            uio = uio_arr[k];
`ifdef HARNESS_OE_MASK_EN
            uio = uio & oe_drv;
`endif
            sig = poly_step(sig) ^ {16'h0000, uio, uo};
            if (k < RUN_LEN - 1) lf = poly_step(lf);
        end
        return sig;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fillConst(input logic [7:0] uo_c, input logic [7:0] uio_c);
        for (int k = 0; k < TOTAL; k++) begin
            uo_arr[k]  = uo_c;
            uio_arr[k] = uio_c;
        end
    endtask

    task automatic fillRandom;
        for (int k = 0; k < TOTAL; k++) begin
            uo_arr[k]  = 8'($urandom);
            uio_arr[k] = 8'($urandom);
        end
    endtask

    // One full run from start pulse to the cycle after DONE.
    task automatic applyStimulus(input bit echo, input int flip_k, input int glitch_k,
                                 input logic [31:0] exp_sig);
        logic [31:0] mdl;
        logic [31:0] lf;
        logic [31:0] lf_last;
        logic        exp_pass;
        int          busy_cnt = 0;
        int          done_cnt = 0;
        int          rst_low  = 0;
        int          stim_err = 0;
        int          hold_err = 0;

        mdl          = model_sig(echo, flip_k);
        exp_pass     = (mdl == exp_sig);
        echo_mode    = echo;
        expected_sig = exp_sig;
        flip_mask    = 8'h00;
        uo_drv       = uo_arr[0];
        uio_drv      = uio_arr[0];

        start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("pass_clr_on_start", 32'(pass), 32'd0);

        for (int i = 0; i < RST_CYCLES; i++) begin
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            rst_low  += int'(dut_rst_n == 1'b0);
            tick;
        end
        checkOutput("rst_n_low_cycles", 32'(rst_low), 32'(RST_CYCLES));

        lf      = SEED;
        lf_last = SEED;
        for (int k = 0; k < RUN_LEN; k++) begin
            uo_drv    = uo_arr[k];
            uio_drv   = uio_arr[k];
            flip_mask = (k == flip_k) ? 8'h01 : 8'h00;
            start     = (k == glitch_k);
            if (k == 0) begin
                checkOutput("first_ui", 32'(dut_ui), 32'h01);
                checkOutput("first_uio_in", 32'(dut_uio_in), 32'h00);
                checkOutput("run_rst_n", 32'(dut_rst_n), 32'd1);
            end
            if (dut_ui !== lf[7:0] || dut_uio_in !== lf[23:16]) stim_err++;
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            lf_last   = lf;
            lf        = poly_step(lf);
            tick;
        end
        start     = 1'b0;
        flip_mask = 8'h00;
        checkOutput("stim_seq_errs", 32'(stim_err), 32'd0);

        for (int d = 0; d < DRAIN_CYCLES; d++) begin
            uo_drv  = uo_arr[RUN_LEN + d];
            uio_drv = uio_arr[RUN_LEN + d];
            if (dut_ui !== lf_last[7:0] || dut_uio_in !== lf_last[23:16]) hold_err++;
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            tick;
        end
        checkOutput("drain_hold_errs", 32'(hold_err), 32'd0);
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(RST_CYCLES + RUN_LEN + DRAIN_CYCLES));
        checkOutput("done_early", 32'(done_cnt), 32'd0);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        checkOutput("signature", signature, mdl);
        checkOutput("pass", 32'(pass), 32'(exp_pass));
        tick;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("pass_held", 32'(pass), 32'(exp_pass));
        checkOutput("sig_held", signature, mdl);
    endtask

    initial begin
        int          done_cnt;
        logic [31:0] ref_sig;

        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        expected_sig = 32'h0;
        echo_mode    = 1'b0;
        flip_mask    = 8'h00;
        uo_drv       = 8'h00;
        uio_drv      = 8'h00;
        oe_drv       = 8'h00;
        fillConst(8'h00, 8'h00);

        // Reset state.
        tick;
        tick;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_sig", signature, 32'h0);
        checkOutput("rst_dut_rst_n", 32'(dut_rst_n), 32'd0);
        checkOutput("rst_ena", 32'(dut_ena), 32'd0);
        checkOutput("rst_ui", 32'(dut_ui), 32'd0);
        checkOutput("rst_uio_in", 32'(dut_uio_in), 32'd0);
        rst = 1'b0;
        tick;
        checkOutput("idle_dut_rst_n", 32'(dut_rst_n), 32'd1);
        checkOutput("idle_ena", 32'(dut_ena), 32'd0);

        $display("[TB] zero-output run");
        fillConst(8'h00, 8'h00);
        applyStimulus(1'b0, -1, -1, 32'h0);

        $display("[TB] echo run with start pulsed mid-run");
        ref_sig = model_sig(1'b1, -1);
        applyStimulus(1'b1, -1, 5, ref_sig);

        $display("[TB] echo run with one flipped uo bit");
        applyStimulus(1'b1, 100, -1, ref_sig);

        $display("[TB] random DUT outputs");
        fillRandom();
        oe_drv  = 8'($urandom);
        ref_sig = model_sig(1'b0, -1);
        applyStimulus(1'b0, -1, -1, ref_sig);
        applyStimulus(1'b0, -1, -1, ref_sig ^ 32'h0000_0100);

        $display("[TB] abort on RUN cycle 10");
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < RST_CYCLES + 10; i++) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_pass", 32'(pass), 32'd0);
        checkOutput("abort_ena", 32'(dut_ena), 32'd0);
        checkOutput("abort_dut_rst_n", 32'(dut_rst_n), 32'd1);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            done_cnt += int'(done) + int'(busy);
        end
        checkOutput("abort_quiet", 32'(done_cnt), 32'd0);
        fillConst(8'h00, 8'h00);
        applyStimulus(1'b1, -1, -1, model_sig(1'b1, -1));

        $display("[TB] start with abort in RST_DUT");
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", 32'(busy), 32'd0);
        tick;
        checkOutput("start_abort_idle", 32'(busy), 32'd0);

        $display("[TB] reset on DRAIN cycle 1");
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < RST_CYCLES + RUN_LEN + 1; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("drain_rst_sig", signature, 32'h0);
        checkOutput("drain_rst_busy", 32'(busy), 32'd0);
        checkOutput("drain_rst_dut_rst_n", 32'(dut_rst_n), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            done_cnt += int'(done);
            tick;
        end
        checkOutput("drain_rst_no_done", 32'(done_cnt), 32'd0);

        $display("[TB] undriven uio bits");
        fillConst(8'h00, 8'hFF);
        oe_drv = 8'h00;
        applyStimulus(1'b0, -1, -1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
